// File: rtl/alu_issue_buf.sv
// Operand issue buffer: FIFO of {a, b, cin} triples feeding a combinational
// adder ALU, with a one-entry registered result slot on a valid/ready output.
module alu_issue_buf #(
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic                     in_cin,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic                     alu_cin,
    input  logic [W-1:0]             alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [W-1:0]             res_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               done_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = 2 * W + 1;

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic [7:0]    done_cnt_q, done_cnt_d;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          deliver;
    logic [EW-1:0] head;

    always_comb begin
        fifo_empty = (count_q == '0);
        in_ready   = (count_q != CntFull);
        push       = in_valid & in_ready;
        // The slot refills whenever it is empty or its current sum is being taken.
        pop        = ~fifo_empty & ((state_q == StEmpty) | res_ready);
        deliver    = (state_q == StFull) & res_ready;
        head       = mem[rd_ptr_q];

        alu_a   = fifo_empty ? '0   : head[EW-1:W+1];
        alu_b   = fifo_empty ? '0   : head[W:1];
        alu_cin = fifo_empty ? 1'b0 : head[0];
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
        res_data_d = pop  ? alu_out : res_data_q;
        done_cnt_d = deliver ? done_cnt_q + 8'd1 : done_cnt_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            StEmpty: if (pop) state_d = StFull;
            StFull:  if (res_ready && fifo_empty) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StEmpty;
            res_data_q <= '0;
            done_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            res_data_q <= res_data_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_a, in_b, in_cin};
        end
    end

    assign res_valid = (state_q == StFull);
    assign res_data  = res_data_q;
    assign count     = count_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_issue_buf.sv
// Directed bench for alu_issue_buf; the 5-bit adder ALU is modelled inline.
module tb_alu_issue_buf;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_a;
    logic [4:0] in_b;
    logic       in_cin;
    logic [4:0] alu_a;
    logic [4:0] alu_b;
    logic       alu_cin;
    logic [4:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [4:0] res_data;
    logic [2:0] count;
    logic [7:0] done_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_buf #(
        .W     (5),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .count     (count),
        .done_cnt  (done_cnt)
    );

    assign alu_out = alu_a + alu_b + {4'd0, alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b, input logic c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
    endtask

    logic [4:0] bp_a   [6];
    logic [4:0] bp_b   [6];
    logic       bp_c   [6];
    logic [4:0] bp_exp [6];
    logic [4:0] st_a   [16];
    logic [4:0] st_b   [16];
    logic       st_c   [16];
    logic [4:0] st_exp [16];
    logic [7:0] done_base;

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0);

        // Reset state
        tick();
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single op: 7 + 9 + 1 = 17, result two edges after in_valid
        res_ready = 1'b1;
        drive(1'b1, 5'd7, 5'd9, 1'b1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        check("single_lat1_valid", 32'(res_valid), 32'd0);
        check("single_count", 32'(count), 32'd1);
        check("single_alu_a", 32'(alu_a), 32'd7);
        tick();
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_data", 32'(res_data), 32'd17);
        tick();
        check("single_done", 32'(done_cnt), 32'd1);
        check("single_drained", 32'(res_valid), 32'd0);

        // Wrap: 31+1+0 = 0, 31+31+1 = 31 (mod 32)
        drive(1'b1, 5'd31, 5'd1, 1'b0);
        tick();
        drive(1'b1, 5'd31, 5'd31, 1'b1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        check("wrap_first", 32'(res_data), 32'd0);
        check("wrap_first_valid", 32'(res_valid), 32'd1);
        tick();
        check("wrap_second", 32'(res_data), 32'd31);
        tick();
        check("wrap_done", 32'(done_cnt), 32'd3);

        // Backpressure: six pushes with res_ready low, only five fit
        bp_a = '{5'd1, 5'd3, 5'd10, 5'd20, 5'd5, 5'd30};
        bp_b = '{5'd2, 5'd4, 5'd10, 5'd15, 5'd6, 5'd30};
        bp_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bp_exp = '{5'd3, 5'd8, 5'd20, 5'd4, 5'd11, 5'd29};
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, bp_a[i], bp_b[i], bp_c[i]);
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count", 32'(count), 32'd4);
        check("bp_hold", 32'(res_data), 32'(bp_exp[0]));
        tick();
        check("bp_hold2", 32'(res_data), 32'(bp_exp[0]));
        res_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("bp_drain%0d", k), 32'(res_data), 32'(bp_exp[k]));
            check($sformatf("bp_drain_v%0d", k), 32'(res_valid), 32'd1);
            if (k == 1) check("bp_ready_rise", 32'(in_ready), 32'd1);
        end
        tick();
        check("bp_empty", 32'(res_valid), 32'd0);
        check("bp_done", 32'(done_cnt), 32'd8);

        // Streaming: 16 random triples, one result per cycle after fill
        for (int i = 0; i < 16; i++) begin
            st_a[i]   = 5'($urandom_range(0, 31));
            st_b[i]   = 5'($urandom_range(0, 31));
            st_c[i]   = 1'($urandom_range(0, 1));
            st_exp[i] = 5'((32'(st_a[i]) + 32'(st_b[i]) + 32'(st_c[i])) % 32);
        end
        done_base = done_cnt;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b1, st_a[i], st_b[i], st_c[i]);
            else drive(1'b0, 5'd0, 5'd0, 1'b0);
            tick();
            if (i >= 1 && i <= 16) begin
                check($sformatf("st_valid%0d", i - 1), 32'(res_valid), 32'd1);
                check($sformatf("st_data%0d", i - 1), 32'(res_data), 32'(st_exp[i - 1]));
            end
        end
        check("st_done", 32'(done_cnt - done_base), 32'd16);

        // Simultaneous push/pop at count=2
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i + 1), 5'd10, 1'b0);
            tick();
        end
        check("pp_count_pre", 32'(count), 32'd2);
        check("pp_res0", 32'(res_data), 32'd11);
        res_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            drive(1'b1, 5'(i + 1), 5'd10, 1'b0);
            tick();
            check($sformatf("pp_count%0d", i), 32'(count), 32'd2);
            check($sformatf("pp_res%0d", i - 2), 32'(res_data), 32'(i - 2 + 11));
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        tick();
        check("pp_tail4", 32'(res_data), 32'd15);
        tick();
        check("pp_tail5", 32'(res_data), 32'd16);
        tick();
        check("pp_empty", 32'(res_valid), 32'd0);

        // Reset mid-stream with three entries buffered and a pending result
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd4, 5'(i), 1'b1);
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        check("mr_pre_count", 32'(count), 32'd3);
        check("mr_pre_valid", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(res_valid), 32'd0);
        check("mr_count", 32'(count), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_alu", 32'({alu_a, alu_b, alu_cin}), 32'd0);
        check("mr_done", 32'(done_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
        drive(1'b1, 5'd1, 5'd2, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0);
        check("post_count", 32'(count), 32'd1);
        check("post_lat1", 32'(res_valid), 32'd0);
        tick();
        check("post_valid", 32'(res_valid), 32'd1);
        check("post_data", 32'(res_data), 32'd3);
        tick();
        check("post_done", 32'(done_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
